// File: rtl/cvxif_regbank_ctrl.sv
// cvxif_regbank_ctrl: write/dump controller for the CVXIF
// sequential-fill register bank.
//
// Arbitrates two valid/ready writers round-robin onto the bank's single
// write port, mirrors the bank fill count and sequences one-cycle dumps.
// The bank never sees a write at capacity, nor a write and a dump in
// the same cycle.
//
// Ports:
//   clk_i, rst_ni                clock, async active-low reset
//   req0_*/req1_*                writer valid/data/ready (ready = accepted)
//   dump_req_i                   bank clear request, rising-edge qualified
//   bank_we_o/wb_data_o/dump_o   registered drive of the bank
//   fill_count_o, full_o,        fill status from the registered count
//   empty_o, busy_o
//   err_o                        sticky overflow error
//
// Optional feature: `define CVXIF_REGCTRL_OVF_ERR_EN to accept and drop
// writes while full and flag err_o; otherwise full backpressures.
module cvxif_regbank_ctrl #(
    parameter int NB_OF_REGS = 150,
    parameter int REG_WIDTH  = 9,
    parameter int CNT_WIDTH  = $clog2(NB_OF_REGS + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req0_valid_i,
    input  logic [REG_WIDTH-1:0] req0_data_i,
    output logic                 req0_ready_o,
    input  logic                 req1_valid_i,
    input  logic [REG_WIDTH-1:0] req1_data_i,
    output logic                 req1_ready_o,
    input  logic                 dump_req_i,
    output logic                 bank_we_o,
    output logic [REG_WIDTH-1:0] bank_wb_data_o,
    output logic                 bank_dump_o,
    output logic [CNT_WIDTH-1:0] fill_count_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 busy_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL,
        DUMP
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CAP  = CNT_WIDTH'(NB_OF_REGS);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(NB_OF_REGS - 1);

`ifdef CVXIF_REGCTRL_OVF_ERR_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    state_t               state_q, state_d;
    logic                 rr_q;
    logic                 dump_prev_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 we_q;
    logic [REG_WIDTH-1:0] data_q;
    logic                 dump_q;

    logic                 accept_en;
    logic                 gnt0;
    logic                 gnt1;
    logic                 acc;
    logic                 wr;
    logic                 dump_fire;
    logic [REG_WIDTH-1:0] wdata;

    // A held dump request clears the bank only once.
    assign dump_fire = dump_req_i & ~dump_prev_q & (state_q != DUMP);
    assign acc       = gnt0 | gnt1;
    assign wr        = acc & (state_q != FULL) & (cnt_q != CAP);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (dump_fire) begin
                    state_d = DUMP;
                end else if (wr) begin
                    state_d = (cnt_q == LAST) ? FULL : FILL;
                end
            end
            FILL: begin
                if (dump_fire) begin
                    state_d = DUMP;
                end else if (wr && cnt_q == LAST) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (dump_fire) begin
                    state_d = DUMP;
                end
            end
            DUMP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // rr_q set means req1 is favoured on contention.
    always_comb begin
        accept_en = 1'b0;
        unique case (state_q)
            IDLE:    accept_en = 1'b1;
            FILL:    accept_en = 1'b1;
            FULL:    accept_en = OVF_EN;
            DUMP:    accept_en = 1'b0;
            default: accept_en = 1'b0;
        endcase
        if (dump_req_i) begin
            accept_en = 1'b0;
        end
        gnt0 = accept_en & req0_valid_i & (~req1_valid_i | ~rr_q);
        gnt1 = accept_en & req1_valid_i & (~req0_valid_i | rr_q);
        req0_ready_o = gnt0;
        req1_ready_o = gnt1;
    end

    always_comb begin
        wdata = req0_data_i;
        unique case (1'b1)
            gnt1:    wdata = req1_data_i;
            default: wdata = req0_data_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q        <= 1'b0;
            dump_prev_q <= 1'b0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            data_q      <= '0;
            dump_q      <= 1'b0;
        end else begin
            dump_prev_q <= dump_req_i;
            we_q        <= wr;
            dump_q      <= dump_fire;
            if (acc) begin
                rr_q <= gnt0;
            end
            if (wr) begin
                data_q <= wdata;
            end
            if (dump_fire) begin
                cnt_q <= '0;
            end else if (wr) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

`ifdef CVXIF_REGCTRL_OVF_ERR_EN
    logic err_q;
    logic drop;

    // Accepted while full: the data is discarded.
    assign drop = acc & ~wr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (dump_fire) begin
            err_q <= 1'b0;
        end else if (drop) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign bank_we_o      = we_q;
    assign bank_wb_data_o = data_q;
    assign bank_dump_o    = dump_q;
    assign fill_count_o   = cnt_q;
    assign full_o         = (cnt_q == CAP);
    assign empty_o        = (cnt_q == '0);
    assign busy_o         = (state_q == DUMP);

endmodule

// File: tb/tb_cvxif_regbank_ctrl.sv
// tb_cvxif_regbank_ctrl: scoreboard bench for cvxif_regbank_ctrl.
// Follows CVXIF_REGCTRL_OVF_ERR_EN for the overflow expectations.
module tb_cvxif_regbank_ctrl;

    localparam int N = 150;
    localparam int W = 9;
    localparam int C = 8;

`ifdef CVXIF_REGCTRL_OVF_ERR_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_data = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_data = '0;
    logic         req1_ready;
    logic         dump_req = 1'b0;
    logic         bank_we;
    logic [W-1:0] bank_data;
    logic         bank_dump;
    logic [C-1:0] fill_count;
    logic         full;
    logic         empty;
    logic         busy;
    logic         err;

    int total = 0;
    int bad = 0;
    logic [W-1:0] sb[$];

    cvxif_regbank_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req0_valid_i   (req0_valid),
        .req0_data_i    (req0_data),
        .req0_ready_o   (req0_ready),
        .req1_valid_i   (req1_valid),
        .req1_data_i    (req1_data),
        .req1_ready_o   (req1_ready),
        .dump_req_i     (dump_req),
        .bank_we_o      (bank_we),
        .bank_wb_data_o (bank_data),
        .bank_dump_o    (bank_dump),
        .fill_count_o   (fill_count),
        .full_o         (full),
        .empty_o        (empty),
        .busy_o         (busy),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bank-side monitor: every write must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            check("we_dump_excl", 32'(bank_we & bank_dump), 32'd0);
            check("one_ready", 32'(req0_ready & req1_ready), 32'd0);
            if (bank_we) begin
                if (sb.size() == 0) begin
                    check("we_unexpected", 32'(bank_we), 32'd0);
                end else begin
                    check("wdata", 32'(bank_data), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic step(input logic v0, input logic [W-1:0] d0,
                        input logic v1, input logic [W-1:0] d1,
                        input logic dr, input logic [1:0] er,
                        input logic ew, input string tag);
        @(posedge clk);
        #1;
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        dump_req   = dr;
        #1;
        check(tag, 32'({req1_ready, req0_ready}), 32'(er));
        if (ew) sb.push_back(er[1] ? d1 : d0);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0, 2'b00, 1'b0, "idle_rdy");
    endtask

    task automatic stat(input string tag, input int cnt, input logic f,
                        input logic e, input logic b, input logic er);
        check({tag, "_cnt"}, 32'(fill_count), 32'(cnt));
        check({tag, "_full"}, 32'(full), 32'(f));
        check({tag, "_empty"}, 32'(empty), 32'(e));
        check({tag, "_busy"}, 32'(busy), 32'(b));
        check({tag, "_err"}, 32'(err), 32'(er));
    endtask

    task automatic do_dump(input string tag);
        step(1'b0, '0, 1'b1, 9'h055, 1'b1, 2'b00, 1'b0, {tag, "_rdy"});
        step(1'b0, '0, 1'b0, '0, 1'b0, 2'b00, 1'b0, {tag, "_dmp_rdy"});
        check({tag, "_dump"}, 32'(bank_dump), 32'd1);
        check({tag, "_we"}, 32'(bank_we), 32'd0);
        stat({tag, "_d"}, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        check({tag, "_dump_off"}, 32'(bank_dump), 32'd0);
        stat({tag, "_i"}, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        stat("rst", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rst_we", 32'(bank_we), 32'd0);
        check("rst_dump", 32'(bank_dump), 32'd0);
        check("rst_data", 32'(bank_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) idle();
        stat("idle", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_we", 32'(bank_we), 32'd0);

        for (int k = 0; k < 6; k++) begin
            step(1'b1, 9'(9'h100 + k), 1'b1, 9'(9'h080 + k), 1'b0,
                 (k % 2 == 1) ? 2'b10 : 2'b01, 1'b1, "rr");
        end
        idle();
        stat("rr", 6, 1'b0, 1'b0, 1'b0, 1'b0);
        do_dump("dmp1");

        for (int i = 1; i <= N; i++) begin
            step(1'b1, 9'(i), 1'b0, '0, 1'b0, 2'b01, 1'b1, "stream");
        end
        step(1'b1, 9'd151, 1'b0, '0, 1'b0, OVF ? 2'b01 : 2'b00, 1'b0,
             "full_rdy0");
        stat("full", N, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 9'h1FF, 1'b0, OVF ? 2'b10 : 2'b00, 1'b0,
             "ovf_rdy1");
        check("ovf_err1", 32'(err), 32'(OVF));
        idle();
        check("ovf_we", 32'(bank_we), 32'd0);
        stat("ovf", N, 1'b1, 1'b0, 1'b0, OVF);
        do_dump("dmp2");

        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b1, 9'(9'h040 + i), 1'b0, 2'b10, 1'b1, "w10");
        end
        idle();
        stat("w10", 10, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 9'h0EE, 1'b1, 2'b00, 1'b0, "dvw_rdy");
        step(1'b0, '0, 1'b1, 9'h0EF, 1'b1, 2'b00, 1'b0, "dvw_hold");
        check("dvw_dump", 32'(bank_dump), 32'd1);
        check("dvw_we", 32'(bank_we), 32'd0);
        stat("dvw", 0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 9'h0F0, 1'b1, 2'b00, 1'b0, "hold_rdy");
        check("hold_nodump", 32'(bank_dump), 32'd0);
        stat("hold", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 2'b00, 1'b0, "hold_rel");
        check("rel_nodump", 32'(bank_dump), 32'd0);

        for (int i = 0; i < 75; i++) begin
            step(1'b1, 9'(i + 3), 1'b0, '0, 1'b0, 2'b01, 1'b1, "w75");
        end
        idle();
        stat("w75", 75, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        stat("mrst", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("mrst_we", 32'(bank_we), 32'd0);
        check("mrst_dump", 32'(bank_dump), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 9'h0AA, 1'b1, 9'h0BB, 1'b0, 2'b01, 1'b1, "rr_rst");
        step(1'b1, 9'h0AC, 1'b1, 9'h0BD, 1'b0, 2'b10, 1'b1, "rr_rst2");
        idle();
        stat("refill", 2, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
